jogo_memoria_param: RTL
=======================

# jogo_memoria_param

- Parametrised memory-sequence game core, successor to the fixed 4-button base game.
- Button count, sequence depth, LED display time and inactivity timeout are parameters.
- Adds two sequence modes: LFSR-generated or player-appended. Adds an explicit timeout loss.
- Sits under the board top-level. The hexa7seg debug displays are driven from its `db_*` outputs.

## Interface
Parameters:
- `N_BOTOES`, 4: buttons/LEDs, 2..8.
- `PROFUNDIDADE`, 16: rounds to win; sequence RAM depth, power of two, 2..64.
- `LED_CICLOS`, 500: cycles each LED is lit, and cycles of dark gap after it.
- `TIMEOUT_CICLOS`, 3000: idle cycles allowed while waiting for a press.
- `SEMENTE`, 16'hACE1: LFSR reset seed, nonzero.

Ports (W = $clog2(PROFUNDIDADE)):
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low. Low forces all state below immediately.
- `jogar` in 1: start/restart request, level-sampled.
- `modo` in 1: 0 = LFSR sequence, 1 = player appends each new step. Latched in PREPARA.
- `botoes` in N_BOTOES: buttons, active-high.
- `leds` out N_BOTOES: LED drive.
- `ganhou`, `perdeu`, `pronto`, `timeout` out 1 each.
- `db_estado` out 4: state code.
- `db_rodada` out W: current round.
- `db_jogada` out W: current step index.

## Operation
- Storage: RAM PROFUNDIDADE × N_BOTOES of one-hot entries. Round r uses entries 0..r.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Reset to SEED only by `reset`, not by a new game.
  - Advances exactly once per LFSR write.
  - Written entry = one-hot of (lfsr % N_BOTOES), computed before the advance.
- Press detection: event on the cycle registered `botoes` goes from 0 to nonzero. Buttons must return to 0 before the next event.
  - A press with more than one bit set compares unequal.
- States (`db_estado` code):
  - INICIAL 0: idle.
    - `jogar` → PREPARA.
  - PREPARA 1: clear rodada, jogada, timers and flags. Latch `modo`.
    - → GERA.
  - GERA 2: write LFSR entry at index rodada, but only if modo=0 or rodada=0.
    - → MOSTRA_LED. Zero jogada.
  - MOSTRA_LED 3: `leds` = RAM[jogada] for LED_CICLOS cycles.
    - → MOSTRA_APAGA.
  - MOSTRA_APAGA 4: `leds`=0 for LED_CICLOS cycles.
    - jogada<rodada: jogada+1 → MOSTRA_LED.
    - Otherwise: zero jogada → ESPERA.
  - ESPERA 5: `leds` = registered `botoes`. Timer runs.
    - Press event → COMPARA.
    - Timer reaches TIMEOUT_CICLOS-1 → FIM_TIMEOUT.
  - COMPARA 6: compare press with RAM[jogada].
    - Unequal → FIM_PERDEU.
    - Equal, jogada<rodada: jogada+1, zero timer → ESPERA.
    - Equal, jogada=rodada, rodada=PROFUNDIDADE-1 → FIM_GANHOU.
    - Equal, jogada=rodada, modo=1 → ESPERA_NOVA.
    - Equal, jogada=rodada, modo=0: rodada+1 → GERA.
  - ESPERA_NOVA 7: timer runs.
    - Press event → GRAVA_NOVA.
    - Timeout → FIM_TIMEOUT.
  - GRAVA_NOVA 8: write registered press to RAM[rodada+1]. Multi-bit presses are stored as-is and cannot be matched later.
    - rodada+1 → GERA. GERA performs no write here.
  - FIM_GANHOU A: `ganhou`=1, `pronto`=1.
  - FIM_PERDEU E: `perdeu`=1, `pronto`=1.
  - FIM_TIMEOUT F: `perdeu`=1, `timeout`=1, `pronto`=1.
- Final states hold until `jogar` → PREPARA.
- `jogar` is ignored in every state except INICIAL and the final states.
- Reset (low at any time, including mid-sequence or mid-write):
  - State INICIAL. Every output 0. Counters 0. LFSR = SEED.
  - RAM contents undefined and never read before being rewritten.

## Timing
- `jogar` sampled high at edge k:
  - PREPARA at k+1, GERA at k+2, MOSTRA_LED at k+3.
  - First LED visible from k+3 for exactly LED_CICLOS cycles.
- Status and `db_*` outputs are Moore, decoded from registered state and counters.
- Press-to-COMPARA latency:
  - Input register, then edge detect in ESPERA.
  - COMPARA is the state two edges after `botoes` rises.
  - Result state one edge later.
- Timeout: counts idle cycles in ESPERA/ESPERA_NOVA. Exactly TIMEOUT_CICLOS cycles without an event → FIM_TIMEOUT on the next edge.
- A press event and timer expiry in the same cycle: the press wins.
- Round counter never wraps: FIM_GANHOU is taken before rodada would exceed PROFUNDIDADE-1.

## Test plan
Bench parameters: N_BOTOES=4, PROFUNDIDADE=4, LED_CICLOS=4, TIMEOUT_CICLOS=20.
- Reset then idle:
  - All outputs 0, `db_estado`=0.
  - Pulse `jogar`: `db_estado` 1,2,3 on the next three edges.
  - `leds` one-hot for exactly 4 cycles, then 0 for 4.
- modo=0 full win:
  - Replay each round's displayed LEDs, releasing between presses.
  - After round 3: `ganhou`=`pronto`=1, `db_estado`=A, `db_rodada`=3.
- Wrong press in round 1 step 0 → `perdeu`=1, `timeout`=0, `db_estado`=E.
- No press for 20 cycles in ESPERA → `perdeu`=`timeout`=1, `db_estado`=F.
- modo=1:
  - Round 0 correct, then press 0100 in ESPERA_NOVA.
  - Round 1 displays LED0 entry then 0100.
  - Held button counts once. Pressing 0011 → perdeu.
- Reset low mid-MOSTRA_LED:
  - Outputs 0 immediately.
  - Second game after reset replays an identical first LED (LFSR reseeded).

Source files
------------

// File: rtl/jogo_memoria_param_if.sv
// jogo_memoria_param_if: game-core I/O bundle (player controls, LEDs, status, debug).
interface jogo_memoria_param_if #(
  parameter int N_BOTOES     = 4,
  parameter int PROFUNDIDADE = 16
);
  localparam int W = $clog2(PROFUNDIDADE);
  logic                jogar;
  logic                modo;
  logic [N_BOTOES-1:0] botoes;
  logic [N_BOTOES-1:0] leds;
  logic                ganhou;
  logic                perdeu;
  logic                pronto;
  logic                timeout;
  logic [3:0]          db_estado;
  logic [W-1:0]        db_rodada;
  logic [W-1:0]        db_jogada;
  modport master (
    output jogar, modo, botoes,
    input  leds, ganhou, perdeu, pronto, timeout, db_estado, db_rodada, db_jogada
  );
  modport slave (
    input  jogar, modo, botoes,
    output leds, ganhou, perdeu, pronto, timeout, db_estado, db_rodada, db_jogada
  );
endinterface

// File: rtl/jogo_memoria_param.sv
// jogo_memoria_param: parametrised memory-sequence game with LFSR or player-appended sequences.
module jogo_memoria_param #(
  parameter int          N_BOTOES       = 4,
  parameter int          PROFUNDIDADE   = 16,
  parameter int          LED_CICLOS     = 500,
  parameter int          TIMEOUT_CICLOS = 3000,
  parameter logic [15:0] SEMENTE        = 16'hACE1
) (
  input logic            clock,
  input logic            reset,
  jogo_memoria_param_if.slave bus
);
  localparam int W    = $clog2(PROFUNDIDADE);
  localparam int CMAX = LED_CICLOS > TIMEOUT_CICLOS ? LED_CICLOS : TIMEOUT_CICLOS;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [3:0] INICIAL      = 4'h0;
  localparam logic [3:0] PREPARA      = 4'h1;
  localparam logic [3:0] GERA         = 4'h2;
  localparam logic [3:0] MOSTRA_LED   = 4'h3;
  localparam logic [3:0] MOSTRA_APAGA = 4'h4;
  localparam logic [3:0] ESPERA       = 4'h5;
  localparam logic [3:0] COMPARA      = 4'h6;
  localparam logic [3:0] ESPERA_NOVA  = 4'h7;
  localparam logic [3:0] GRAVA_NOVA   = 4'h8;
  localparam logic [3:0] FIM_GANHOU   = 4'hA;
  localparam logic [3:0] FIM_PERDEU   = 4'hE;
  localparam logic [3:0] FIM_TIMEOUT  = 4'hF;

  logic [3:0]          estado_q, estado_d;
  logic [W-1:0]        rodada_q, rodada_d, jogada_q, jogada_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [15:0]         lfsr_q, lfsr_d, lfsr_idx;
  logic                modo_q, modo_d;
  logic [N_BOTOES-1:0] bot_q, bot_prev_q, press_q, press_d;
  logic [N_BOTOES-1:0] ram_q [PROFUNDIDADE];
  logic [N_BOTOES-1:0] ram_din, ram_rd;
  logic [W-1:0]        ram_addr;
  logic                ram_we, evento, fim_led, expira;

  assign evento   = |bot_q & ~|bot_prev_q;
  assign ram_rd   = ram_q[jogada_q];
  assign fim_led  = cnt_q == CW'(LED_CICLOS - 1);
  assign expira   = cnt_q == CW'(TIMEOUT_CICLOS - 1);
  assign lfsr_idx = lfsr_q % 16'(N_BOTOES);

  always_comb begin
    estado_d = estado_q;
    rodada_d = rodada_q;
    jogada_d = jogada_q;
    cnt_d    = '0;
    lfsr_d   = lfsr_q;
    modo_d   = modo_q;
    press_d  = press_q;
    ram_we   = 1'b0;
    ram_addr = rodada_q;
    ram_din  = N_BOTOES'(1) << lfsr_idx;
    case (estado_q)
      INICIAL, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: estado_d = bus.jogar ? PREPARA : estado_q;
      PREPARA: begin
        rodada_d = '0;
        jogada_d = '0;
        modo_d   = bus.modo;
        estado_d = GERA;
      end
      GERA: begin
        // Player-appended rounds already hold their new entry from GRAVA_NOVA
        ram_we   = !modo_q || rodada_q == '0;
        lfsr_d   = ram_we ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
        jogada_d = '0;
        estado_d = MOSTRA_LED;
      end
      MOSTRA_LED: begin
        cnt_d    = fim_led ? '0 : cnt_q + 1'b1;
        estado_d = fim_led ? MOSTRA_APAGA : estado_q;
      end
      MOSTRA_APAGA: begin
        cnt_d    = fim_led ? '0 : cnt_q + 1'b1;
        estado_d = !fim_led ? estado_q : jogada_q < rodada_q ? MOSTRA_LED : ESPERA;
        jogada_d = !fim_led ? jogada_q : jogada_q < rodada_q ? jogada_q + 1'b1 : '0;
      end
      ESPERA, ESPERA_NOVA: begin
        // A press in the expiry cycle still wins over the timeout
        cnt_d    = (evento || expira) ? '0 : cnt_q + 1'b1;
        press_d  = evento ? bot_q : press_q;
        estado_d = evento ? (estado_q == ESPERA ? COMPARA : GRAVA_NOVA)
                 : expira ? FIM_TIMEOUT : estado_q;
      end
      COMPARA: begin
        estado_d = press_q != ram_rd               ? FIM_PERDEU
                 : jogada_q < rodada_q             ? ESPERA
                 : rodada_q == W'(PROFUNDIDADE - 1) ? FIM_GANHOU
                 : modo_q                          ? ESPERA_NOVA : GERA;
        jogada_d = (press_q == ram_rd && jogada_q < rodada_q) ? jogada_q + 1'b1 : jogada_q;
        rodada_d = (estado_d == GERA) ? rodada_q + 1'b1 : rodada_q;
      end
      GRAVA_NOVA: begin
        ram_we   = 1'b1;
        ram_addr = rodada_q + 1'b1;
        ram_din  = press_q;
        rodada_d = rodada_q + 1'b1;
        estado_d = GERA;
      end
      default: estado_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= INICIAL;
      rodada_q   <= '0;
      jogada_q   <= '0;
      cnt_q      <= '0;
      lfsr_q     <= SEMENTE;
      modo_q     <= 1'b0;
      press_q    <= '0;
      bot_q      <= '0;
      bot_prev_q <= '0;
    end else begin
      estado_q   <= estado_d;
      rodada_q   <= rodada_d;
      jogada_q   <= jogada_d;
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
      modo_q     <= modo_d;
      press_q    <= press_d;
      bot_q      <= bus.botoes;
      bot_prev_q <= bot_q;
    end
  end

  always_ff @(posedge clock) begin
    if (ram_we) ram_q[ram_addr] <= ram_din;
  end

  assign bus.leds      = estado_q == MOSTRA_LED ? ram_rd : estado_q == ESPERA ? bot_q : '0;
  assign bus.ganhou    = estado_q == FIM_GANHOU;
  assign bus.perdeu    = estado_q == FIM_PERDEU || estado_q == FIM_TIMEOUT;
  assign bus.timeout   = estado_q == FIM_TIMEOUT;
  assign bus.pronto    = estado_q == FIM_GANHOU || estado_q == FIM_PERDEU || estado_q == FIM_TIMEOUT;
  assign bus.db_estado = estado_q;
  assign bus.db_rodada = rodada_q;
  assign bus.db_jogada = jogada_q;
endmodule
